bit_serial_n: RTL and testbench

BIT_SERIAL_N -- requirements
Module: bit_serial_n

---
 rtl/bit_serial_n_if.sv | 32 +++
 rtl/bit_serial_n.sv | 153 +++++++++++++++
 tb/tb_bit_serial_n.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_n_if.sv
// bit_serial_n_if -- instruction/operand/status bundle for bit_serial_n.
// Parameter W : data width, must match the attached bit_serial_n.
// Signals:
//   i_data_instruction [2:0]  opcode addressed by the external PC
//   i_data_switch      [W-1:0] operand word
//   i_start                    start request
//   o_con_pcincr               PC-advance pulse
//   o_data_display     [W-1:0] display word
//   o_carry                    carry flag
//   o_busy                     high while not idle
// Modports: master (sequencer/PC side), slave (the core).
interface bit_serial_n_if #(
  parameter int unsigned W = 8
);
  logic [2:0]   i_data_instruction;
  logic [W-1:0] i_data_switch;
  logic         i_start;
  logic         o_con_pcincr;
  logic [W-1:0] o_data_display;
  logic         o_carry;
  logic         o_busy;

  modport master (
    output i_data_instruction, i_data_switch, i_start,
    input  o_con_pcincr, o_data_display, o_carry, o_busy
  );

  modport slave (
    input  i_data_instruction, i_data_switch, i_start,
    output o_con_pcincr, o_data_display, o_carry, o_busy
  );
endinterface

// File: rtl/bit_serial_n.sv
// bit_serial_n -- bit-serial accumulator machine driven by an external PC.
// Instructions are decoded one per DECODE cycle; LOAD/DISP/NOP finish in
// that cycle, ADD/SUB/AND/OR walk the accumulator LSB first over W SHIFT
// cycles. o_con_pcincr tells the external PC to step at the next edge.
// Parameter W : data/accumulator width, 2..32.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    bit_serial_n_if.slave (opcode, operand, start, pcincr,
//          display, carry, busy)
// Build option: define BIT_SERIAL_ADC_EN to turn opcode 111 into ADC
// (serial add seeded with o_carry); otherwise 111 is a NOP.
module bit_serial_n #(
  parameter int unsigned W = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  bit_serial_n_if.slave bus
);

`ifdef BIT_SERIAL_ADC_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, DECODE, SHIFT} state_e;

  typedef enum logic [2:0] {
    OP_HALT = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_DISP = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_EXT  = 3'b111
  } op_e;

  state_e        state;
  op_e           opcode;
  op_e           sop;       // serial op latched in DECODE
  logic [W-1:0]  acc;
  logic [W-1:0]  b;
  logic [CW-1:0] cnt;
  logic          c;         // running serial carry
  logic [W-1:0]  display;
  logic          carry;
  logic          busy_r;
  logic          pcincr;

  logic sum, cout, r, arith;

  assign opcode = op_e'(bus.i_data_instruction);

  always_comb begin
    sum   = acc[0] ^ b[0] ^ c;
    cout  = (acc[0] & b[0]) | (acc[0] & c) | (b[0] & c);
    arith = (sop == OP_ADD) || (sop == OP_SUB) || (sop == OP_EXT);
    case (sop)
      OP_AND:  r = acc[0] & b[0];
      OP_OR:   r = acc[0] | b[0];
      default: r = sum;
    endcase
  end

  // The PC must step at the same edge that consumes the instruction, so
  // the pulse is decoded from the live opcode rather than registered.
  always_comb begin
    pcincr = 1'b0;
    if (!i_rst) begin
      case (state)
        DECODE: pcincr = (opcode == OP_LOAD) || (opcode == OP_DISP) ||
                         ((opcode == OP_EXT) && !ADC_EN);
        SHIFT:  pcincr = (cnt == LAST);
        default: pcincr = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      sop     <= OP_HALT;
      acc     <= '0;
      b       <= '0;
      cnt     <= '0;
      c       <= 1'b0;
      display <= '0;
      carry   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state  <= DECODE;
            busy_r <= 1'b1;
          end
        end
        DECODE: begin
          case (opcode)
            OP_HALT: begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
            OP_LOAD: acc     <= bus.i_data_switch;
            OP_DISP: display <= acc;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              // SUB is acc + ~operand + 1: invert B and seed carry with 1.
              b     <= (opcode == OP_SUB) ? ~bus.i_data_switch : bus.i_data_switch;
              c     <= (opcode == OP_SUB);
              cnt   <= '0;
              sop   <= opcode;
              state <= SHIFT;
            end
            OP_EXT: begin
              if (ADC_EN) begin
                b     <= bus.i_data_switch;
                c     <= carry;
                cnt   <= '0;
                sop   <= OP_EXT;
                state <= SHIFT;
              end
            end
          endcase
        end
        SHIFT: begin
          acc <= {r, acc[W-1:1]};
          b   <= b >> 1;
          cnt <= cnt + CW'(1);
          if (arith) c <= cout;
          if (cnt == LAST) begin
            state <= DECODE;
            if (arith) carry <= cout;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_con_pcincr   = pcincr;
  assign bus.o_data_display = display;
  assign bus.o_carry        = carry;
  assign bus.o_busy         = busy_r & ~i_rst;

endmodule

// File: tb/tb_bit_serial_n.sv
// tb_bit_serial_n -- scoreboard bench for bit_serial_n (W = 8).
// Programs are small instruction tables fetched through a bench-side PC
// that steps on o_con_pcincr; unprogrammed addresses read HALT. Each PC
// pulse is matched against a queue of expected pulses (PC, cycles spent
// on the instruction, display and carry afterwards).
module tb_bit_serial_n;
  localparam int unsigned W = 8;

  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] DISP = 3'b100;
  localparam logic [2:0] AND_ = 3'b101;
  localparam logic [2:0] OR_  = 3'b110;
  localparam logic [2:0] EXT  = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serial_n_if #(.W(W)) bus_if();

  bit_serial_n #(.W(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  typedef struct {
    int           pc;
    int           lat;
    logic [W-1:0] disp;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_e;
  bit   pend = 1'b0;
  bit   adv  = 1'b0;
  int   nvec = 0;
  int   nfail = 0;
  int   pc = 0;
  int   lat = 0;
  int   pulses = 0;
  int   plen = 0;
  logic [2:0]   prog_op[16];
  logic [W-1:0] prog_sw[16];

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Append an instruction; lat = 0 means it produces no PC pulse.
  task automatic ins(input logic [2:0] op, input logic [W-1:0] sw,
                     input int l, input logic [W-1:0] d, input logic cy);
    exp_t e;
    prog_op[plen] = op;
    prog_sw[plen] = sw;
    if (l > 0) begin
      e.pc = plen; e.lat = l; e.disp = d; e.c = cy;
      exp_q.push_back(e);
    end
    plen++;
  endtask

  task automatic drive_ins();
    if (pc < plen) begin
      bus_if.i_data_instruction = prog_op[pc];
      bus_if.i_data_switch      = prog_sw[pc];
    end else begin
      bus_if.i_data_instruction = 3'b000;
      bus_if.i_data_switch      = '0;
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        check($sformatf("disp_after_pc%0d", pend_e.pc), int'(bus_if.o_data_display), int'(pend_e.disp));
        check($sformatf("carry_after_pc%0d", pend_e.pc), int'(bus_if.o_carry), int'(pend_e.c));
        pend = 1'b0;
      end
      if (rst || !bus_if.o_busy) begin
        lat = 0;
        if (bus_if.o_con_pcincr) begin
          nvec++; nfail++;
          $display("FAIL pcincr_while_idle: got 1, expected 0");
        end
      end else if (bus_if.o_con_pcincr) begin
        pulses++;
        if (exp_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL unexpected_pcincr: pc %0d, expected no pulse", pc);
        end else begin
          pend_e = exp_q.pop_front();
          check("pulse_pc", pc, pend_e.pc);
          check($sformatf("latency_pc%0d", pend_e.pc), lat + 1, pend_e.lat);
          pend = 1'b1;
        end
        adv = 1'b1;
        lat = 0;
      end else begin
        lat++;
      end
    end
  end

  // Run the loaded program from PC 0. rst_at/start_at inject a reset or a
  // stray start pulse at that loop cycle (-1 = never).
  task automatic run(input string name, input int rst_at, input int start_at,
                     input logic [W-1:0] fin_d, input logic fin_c);
    int npush;
    bit done;
    npush  = exp_q.size();
    pulses = 0;
    pc     = 0;
    adv    = 1'b0;
    done   = 1'b0;
    drive_ins();
    bus_if.i_start = 1'b1;
    @(posedge clk); #1;
    bus_if.i_start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        check({name, "_rst_disp"},  int'(bus_if.o_data_display), 0);
        check({name, "_rst_carry"}, int'(bus_if.o_carry), 0);
        check({name, "_rst_busy"},  int'(bus_if.o_busy), 0);
        done = 1'b1;
        break;
      end
      if (adv) pc++;
      adv = 1'b0;
      drive_ins();
      bus_if.i_start = (cyc == start_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({name, "_busy_in_rst"},   int'(bus_if.o_busy), 0);
        check({name, "_pcincr_in_rst"}, int'(bus_if.o_con_pcincr), 0);
      end else if (!bus_if.o_busy) begin
        done = 1'b1;
        break;
      end
    end
    bus_if.i_start = 1'b0;
    check({name, "_completed"}, int'(done), 1);
    check({name, "_final_disp"},  int'(bus_if.o_data_display), int'(fin_d));
    check({name, "_final_carry"}, int'(bus_if.o_carry), int'(fin_c));
    check({name, "_pulse_count"}, pulses, npush);
    exp_q.delete();
    plen = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.i_start = 1'b0;
    bus_if.i_data_instruction = 3'b000;
    bus_if.i_data_switch = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_disp",   int'(bus_if.o_data_display), 0);
    check("reset_carry",  int'(bus_if.o_carry), 0);
    check("reset_busy",   int'(bus_if.o_busy), 0);
    check("reset_pcincr", int'(bus_if.o_con_pcincr), 0);

    // LOAD, DISP, HALT
    ins(LOAD, 8'hF0, 1, 8'h00, 1'b0);
    ins(DISP, 8'h00, 1, 8'hF0, 1'b0);
    run("load_disp", -1, -1, 8'hF0, 1'b0);

    // 0xF0 + 0x20 overflows: 0x10, carry 1
    ins(LOAD, 8'hF0, 1, 8'hF0, 1'b0);
    ins(ADD,  8'h20, 9, 8'hF0, 1'b1);
    ins(DISP, 8'h00, 1, 8'h10, 1'b1);
    run("add", -1, -1, 8'h10, 1'b1);

    // 5 - 7 borrows
    ins(LOAD, 8'h05, 1, 8'h10, 1'b1);
    ins(SUB,  8'h07, 9, 8'h10, 1'b0);
    ins(DISP, 8'h00, 1, 8'hFE, 1'b0);
    run("sub_borrow", -1, -1, 8'hFE, 1'b0);

    // 7 - 5 no borrow
    ins(LOAD, 8'h07, 1, 8'hFE, 1'b0);
    ins(SUB,  8'h05, 9, 8'hFE, 1'b1);
    ins(DISP, 8'h00, 1, 8'h02, 1'b1);
    run("sub_noborrow", -1, -1, 8'h02, 1'b1);

    // AND keeps carry=1; stray start mid-run must be ignored
    ins(LOAD, 8'hCC, 1, 8'h02, 1'b1);
    ins(AND_, 8'hAA, 9, 8'h02, 1'b1);
    ins(DISP, 8'h00, 1, 8'h88, 1'b1);
    run("and_start_busy", -1, 3, 8'h88, 1'b1);

    // 0 - 1 = 0xFF with borrow, then OR keeps carry=0
    ins(LOAD, 8'h00, 1, 8'h88, 1'b1);
    ins(SUB,  8'h01, 9, 8'h88, 1'b0);
    ins(LOAD, 8'hCC, 1, 8'h88, 1'b0);
    ins(OR_,  8'hAA, 9, 8'h88, 1'b0);
    ins(DISP, 8'h00, 1, 8'hEE, 1'b0);
    run("or", -1, -1, 8'hEE, 1'b0);

    // reset during the 4th SHIFT cycle of ADD discards everything
    ins(LOAD, 8'hF0, 1, 8'hEE, 1'b0);
    ins(ADD,  8'h20, 0, 8'h00, 1'b0);
    run("rst_mid_add", 4, -1, 8'h00, 1'b0);

    ins(LOAD, 8'hF0, 1, 8'h00, 1'b0);
    ins(DISP, 8'h00, 1, 8'hF0, 1'b0);
    run("load_disp_after_rst", -1, -1, 8'hF0, 1'b0);

`ifdef BIT_SERIAL_ADC_EN
    // 0xFF + 1 -> 0x00 carry 1; ADC 0 -> 0x01 carry 0
    ins(LOAD, 8'hFF, 1, 8'hF0, 1'b0);
    ins(ADD,  8'h01, 9, 8'hF0, 1'b1);
    ins(EXT,  8'h00, 9, 8'hF0, 1'b0);
    ins(DISP, 8'h00, 1, 8'h01, 1'b0);
    run("adc", -1, -1, 8'h01, 1'b0);
`else
    // opcode 111 is a one-cycle NOP: acc stays 0x3C
    ins(LOAD, 8'h3C, 1, 8'hF0, 1'b0);
    ins(EXT,  8'hFF, 1, 8'hF0, 1'b0);
    ins(DISP, 8'h00, 1, 8'h3C, 1'b0);
    run("nop", -1, -1, 8'h3C, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
